// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default geometry/latency and the word-index width for the default depth.
package mem_responder_pkg;

  localparam int DEFAULT_DEPTH = 2048;
  localparam int DEFAULT_LAT   = 2;
  localparam int WORD_IDX_W    = $clog2(DEFAULT_DEPTH);

  // Binary-encoded FSM state; constants kept as plain localparams so older
  // code that compares raw 2-bit values keeps working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word array. Storage is never reset; only the
// registered read-data port is cleared, so RDATA reads 0 after RESET.
module mem_array_sp
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write port: one word per enabled edge, contents survive reset.
  always_ff @(posedge CLK) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read register: loads only on a read strobe, otherwise holds its value.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a CPU 4-phase handshake. A request is captured in
// IDLE, waits LAT cycles, then the access happens on the edge entering RESP
// where READY/ERR are registered.
//
// Handshake: REQ rises with WE/ADDR/WDATA stable; READY rises (registered)
// LAT+1 edges later counting the capture edge, and stays high until REQ is
// seen low in RESP. If REQ already dropped during WAIT, READY is a 1-cycle
// pulse. New requests are only taken in IDLE.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LAT   = DEFAULT_LAT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        READY,
  output logic        ERR,
  output logic        BUSY,
  output state_t      STATE_DBG
);

  localparam int IDX_W = (DEPTH == DEFAULT_DEPTH) ? WORD_IDX_W : $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        enter_resp;

  // With LAT=0 the access happens on the capture edge itself, so the live
  // inputs are used in IDLE; afterwards the captured copies are used.
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        aligned;
  logic [IDX_W-1:0] acc_idx;

  assign acc_we    = (state_q == ST_IDLE) ? WE    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? ADDR  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? WDATA : wdata_q;
  assign aligned   = (acc_addr[1:0] == 2'b00);
  assign acc_idx   = IDX_W'(acc_addr[31:2] % 30'(DEPTH));

  // Next-state logic for the IDLE/WAIT/RESP handshake FSM and its outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (LAT == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (!REQ) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = !aligned;
    end
  end

  // FSM, counter and response flag registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Request capture: only in IDLE, so later input changes are ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && REQ) begin
      we_q    <= WE;
      addr_q  <= ADDR;
      wdata_q <= WDATA;
    end
  end

  mem_array_sp #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .we_i    (enter_resp && aligned && acc_we),
    .re_i    (enter_resp && aligned && !acc_we),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (RDATA)
  );

  assign READY     = ready_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign STATE_DBG = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 2048: number of 32-bit words in storage.
REQ-002 Parameter LAT, default 2: wait cycles between request capture and response (range 0..15).
REQ-003 Clock and reset: CLK and RESET. CLK is the clock. RESET is asynchronous and active-high.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RESET  input  1  asynchronous active-high reset.
REQ-006 REQ  input  1  transaction request from the CPU, 4-phase handshake.
REQ-007 WE  input  1  1 = write, 0 = read; qualified by REQ.
REQ-008 ADDR  input  32  byte address; word index = ADDR[31:2] mod DEPTH.
REQ-009 WDATA  input  32  write data.
REQ-010 RDATA  output  32  registered read data.
REQ-011 READY  output  1  response valid; held until REQ drops.
REQ-012 ERR  output  1  misaligned-access flag; valid while READY=1.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 FSM states are IDLE, WAIT and RESP, with binary encoding.
REQ-015 IDLE with REQ=1 captures WE, ADDR and WDATA into internal registers on the same edge.
- LAT>0: next state WAIT, counter loaded with LAT-1.
- LAT=0: next state RESP directly.
REQ-016 In WAIT, the counter decrements each cycle; counter=0 moves to RESP on the next edge.
REQ-017 Edges from REQ capture to READY rising = LAT+1; READY is registered, with no combinational path from REQ.
REQ-018 On entry to RESP, ERR is set to 1 when the captured ADDR[1:0] is not 00, otherwise 0.
REQ-019 On entry to RESP, an aligned write stores the captured WDATA at the word index, exactly once per transaction.
REQ-020 On entry to RESP, an aligned read loads RDATA from the word index.
REQ-021 A misaligned access performs no write, leaves RDATA unchanged and sets ERR=1.
REQ-022 RESP holds READY=1 while REQ=1; REQ=0 in RESP moves to IDLE with READY=0 and ERR=0 on that edge.
REQ-023 The requester holds WE, ADDR and WDATA stable from REQ rise until READY rises; input changes during WAIT or RESP are ignored because the captured copies are used.
REQ-024 REQ falling during WAIT does not abort: the transaction completes, READY pulses for one cycle, and the FSM returns to IDLE.
REQ-025 A new request is accepted only from IDLE, so back-to-back transactions are separated by at least one IDLE cycle.
REQ-026 RDATA holds the last read value across writes, errors and idle periods.
REQ-027 Address wrap: word index ADDR[31:2] mod DEPTH, so for example byte address 0x2000 with DEPTH=2048 maps to word 0.
REQ-028 Read-after-write to the same word in consecutive transactions returns the new data.

Reset
REQ-029 RESET=1 forces state IDLE, READY=0, ERR=0, BUSY=0, RDATA=0 and counter=0 immediately.
REQ-030 Reset during WAIT aborts the transaction: no write occurs and no READY is issued.
REQ-031 Storage contents are not cleared by RESET; initial contents are loaded by simulation initialisation only.
REQ-032 The first request is accepted on the first rising edge after RESET deasserts.

Structure
REQ-033 A shared package holds:
- the state typedef (IDLE/WAIT/RESP);
- the default DEPTH and LAT constants;
- the word-index width constant (clog2 of DEPTH).
REQ-034 One sub-module, mem_array_sp: a single-port synchronous array with write enable, word address, write data and registered read data; the FSM and handshake stay in mem_responder.

Verification
REQ-035 LAT=2 aligned read of ADDR=0x10 preloaded with 4 -> READY rises exactly 3 edges after REQ is sampled, RDATA=4, ERR=0, BUSY high for 3 cycles.
REQ-036 Write ADDR=0x1C, WDATA=0xDEADBEEF, then read ADDR=0x1C -> RDATA=0xDEADBEEF; between the transactions READY drops within 1 edge of REQ=0.
REQ-037 Write ADDR=0x1E (misaligned), WDATA=0x55, then read 0x1C -> first transaction ERR=1 and RDATA unchanged; read returns prior contents, ERR=0.
REQ-038 Assert RESET while in WAIT of a write to 0x40 -> READY never rises, BUSY=0 immediately, a subsequent read of 0x40 returns the original value.
REQ-039 LAT=0, read ADDR=0x2004 with DEPTH=2048 -> READY one edge after capture, RDATA = word 1 contents (wrap).
REQ-040 Hold REQ=1 in RESP for 5 cycles with ADDR changing -> READY stays 1, RDATA stable, no second access until REQ drops and an IDLE cycle passes.
